// File: rtl/fu_issue_arbiter_pkg.sv
// Shared widths, lane indices and lane FSM encoding for fu_issue_arbiter.
// Index helpers keep wfid arithmetic modulo NUM_WF rather than 2^WFID_W.
`ifndef WF_PER_CU
`define WF_PER_CU 40
`endif
`ifndef WF_ID_LENGTH
`define WF_ID_LENGTH 6
`endif

package fu_issue_arbiter_pkg;

  localparam int NUM_WF = `WF_PER_CU;
  localparam int WFID_W = `WF_ID_LENGTH;
  localparam int NUM_FU = 4;

  localparam int FU_SIMD = 0;
  localparam int FU_SIMF = 1;
  localparam int FU_SALU = 2;
  localparam int FU_LSU  = 3;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ISSUE = 1'b1;

  function automatic logic [WFID_W-1:0] wf_inc(
    input logic [WFID_W-1:0] id
  );
    return (int'(id) == NUM_WF - 1) ? '0 : id + 1'b1;
  endfunction

  function automatic logic [NUM_WF-1:0] wf_bit(
    input logic [WFID_W-1:0] id
  );
    logic [NUM_WF-1:0] one;
    one = {{(NUM_WF-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

endpackage

// File: rtl/fu_issue_lane_arb.sv
// One FU issue lane: round-robin pick, valid/ready hold and flush drop.
// A handshake restarts the search just past the accepted wfid.
module fu_issue_lane_arb
  import fu_issue_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_WF-1:0] cand,
  input  logic [NUM_WF-1:0] lock,
  input  logic              flush_valid,
  input  logic [WFID_W-1:0] flush_wfid,
  input  logic              issue_ready,
  output logic              issue_valid,
  output logic [WFID_W-1:0] issue_wfid,
  output logic [NUM_WF-1:0] pick,
  output logic              accept
);

  logic              state;
  logic [WFID_W-1:0] rr_ptr;
  logic [WFID_W-1:0] ptr_eff;
  logic [WFID_W-1:0] sel;
  logic [NUM_WF-1:0] elig;
  logic              found;
  logic              can_pick;
  int                idx;

  assign issue_valid = (state == ST_ISSUE);
  assign accept      = issue_valid & issue_ready;
  assign ptr_eff     = accept ? wf_inc(issue_wfid) : rr_ptr;
  assign elig        = cand & ~lock;
  assign can_pick    = (state == ST_IDLE) | accept;
  assign pick        = (can_pick & found) ? wf_bit(sel) : '0;

  // first eligible wfid at or after ptr_eff, wrapping at NUM_WF
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_WF; k++) begin
      idx = int'(ptr_eff) + k;
      if (idx >= NUM_WF) idx = idx - NUM_WF;
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = WFID_W'(idx);
      end
    end
  end

  // lane state, held wfid and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      issue_wfid <= '0;
      rr_ptr     <= '0;
    end else begin
      if (accept) rr_ptr <= ptr_eff;
      if (can_pick) begin
        if (found) begin
          state      <= ST_ISSUE;
          issue_wfid <= sel;
        end else begin
          state <= ST_IDLE;
        end
      end else if (flush_valid && flush_wfid == issue_wfid) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: rtl/fu_issue_arbiter.sv
// Four-lane FU issue scheduler: lock chain SIMD>SIMF>SALU>LSU, issued_mask.
// FU_ARB_PERF_CNT_EN adds perf_clr and saturating per-lane stall counters.
module fu_issue_arbiter
  import fu_issue_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_WF-1:0] wf_ready,
  input  logic [NUM_WF-1:0] fu_simd,
  input  logic [NUM_WF-1:0] fu_simf,
  input  logic [NUM_WF-1:0] fu_salu,
  input  logic [NUM_WF-1:0] fu_lsu,
  input  logic              flush_valid,
  input  logic [WFID_W-1:0] flush_wfid,
  input  logic              simd_issue_ready,
  input  logic              simf_issue_ready,
  input  logic              salu_issue_ready,
  input  logic              lsu_issue_ready,
  output logic              simd_issue_valid,
  output logic              simf_issue_valid,
  output logic              salu_issue_valid,
  output logic              lsu_issue_valid,
  output logic [WFID_W-1:0] simd_issue_wfid,
  output logic [WFID_W-1:0] simf_issue_wfid,
  output logic [WFID_W-1:0] salu_issue_wfid,
  output logic [WFID_W-1:0] lsu_issue_wfid,
`ifdef FU_ARB_PERF_CNT_EN
  input  logic              perf_clr,
  output logic [31:0]       simd_stall_cnt,
  output logic [31:0]       simf_stall_cnt,
  output logic [31:0]       salu_stall_cnt,
  output logic [31:0]       lsu_stall_cnt,
`endif
  output logic [NUM_WF-1:0] issued_mask
);

  logic [NUM_WF-1:0] fmask, ready_ok, held;
  logic [NUM_WF-1:0] lock_simd, lock_simf, lock_salu, lock_lsu;
  logic [NUM_WF-1:0] pick_simd, pick_simf, pick_salu, lsu_pick_unused;
  logic              acc_simd, acc_simf, acc_salu, acc_lsu;

  assign fmask    = flush_valid ? wf_bit(flush_wfid) : '0;
  assign ready_ok = wf_ready & ~fmask;

  assign held =
    (simd_issue_valid ? wf_bit(simd_issue_wfid) : '0) |
    (simf_issue_valid ? wf_bit(simf_issue_wfid) : '0) |
    (salu_issue_valid ? wf_bit(salu_issue_wfid) : '0) |
    (lsu_issue_valid  ? wf_bit(lsu_issue_wfid)  : '0);

  assign lock_simd = held;
  assign lock_simf = lock_simd | pick_simd;
  assign lock_salu = lock_simf | pick_simf;
  assign lock_lsu  = lock_salu | pick_salu;

  assign issued_mask =
    (acc_simd ? wf_bit(simd_issue_wfid) : '0) |
    (acc_simf ? wf_bit(simf_issue_wfid) : '0) |
    (acc_salu ? wf_bit(salu_issue_wfid) : '0) |
    (acc_lsu  ? wf_bit(lsu_issue_wfid)  : '0);

  fu_issue_lane_arb u_simd (
    .clk         (clk),
    .rst         (rst),
    .cand        (ready_ok & fu_simd),
    .lock        (lock_simd),
    .flush_valid (flush_valid),
    .flush_wfid  (flush_wfid),
    .issue_ready (simd_issue_ready),
    .issue_valid (simd_issue_valid),
    .issue_wfid  (simd_issue_wfid),
    .pick        (pick_simd),
    .accept      (acc_simd)
  );

  fu_issue_lane_arb u_simf (
    .clk         (clk),
    .rst         (rst),
    .cand        (ready_ok & fu_simf),
    .lock        (lock_simf),
    .flush_valid (flush_valid),
    .flush_wfid  (flush_wfid),
    .issue_ready (simf_issue_ready),
    .issue_valid (simf_issue_valid),
    .issue_wfid  (simf_issue_wfid),
    .pick        (pick_simf),
    .accept      (acc_simf)
  );

  fu_issue_lane_arb u_salu (
    .clk         (clk),
    .rst         (rst),
    .cand        (ready_ok & fu_salu),
    .lock        (lock_salu),
    .flush_valid (flush_valid),
    .flush_wfid  (flush_wfid),
    .issue_ready (salu_issue_ready),
    .issue_valid (salu_issue_valid),
    .issue_wfid  (salu_issue_wfid),
    .pick        (pick_salu),
    .accept      (acc_salu)
  );

  fu_issue_lane_arb u_lsu (
    .clk         (clk),
    .rst         (rst),
    .cand        (ready_ok & fu_lsu),
    .lock        (lock_lsu),
    .flush_valid (flush_valid),
    .flush_wfid  (flush_wfid),
    .issue_ready (lsu_issue_ready),
    .issue_valid (lsu_issue_valid),
    .issue_wfid  (lsu_issue_wfid),
    .pick        (lsu_pick_unused),
    .accept      (acc_lsu)
  );

`ifdef FU_ARB_PERF_CNT_EN
  logic [3:0]  stall;
  logic [31:0] cnt [4];

  assign stall = {
    lsu_issue_valid  & ~lsu_issue_ready,
    salu_issue_valid & ~salu_issue_ready,
    simf_issue_valid & ~simf_issue_ready,
    simd_issue_valid & ~simd_issue_ready
  };

  assign simd_stall_cnt = cnt[FU_SIMD];
  assign simf_stall_cnt = cnt[FU_SIMF];
  assign salu_stall_cnt = cnt[FU_SALU];
  assign lsu_stall_cnt  = cnt[FU_LSU];

  // saturating valid-without-ready cycle counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FU; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (perf_clr) cnt[i] <= '0;
        else if (stall[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Directed and random stimulus for fu_issue_arbiter with a reference model.
// Build with FU_ARB_PERF_CNT_EN to also check the stall counters.
module tb_fu_issue_arbiter;

  localparam int NW = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] wf_ready;
  logic [39:0] fu [4];
  logic        flush_valid;
  logic [5:0]  flush_wfid;
  logic        rdy [4];
  logic        v [4];
  logic [5:0]  w [4];
  logic [39:0] issued_mask;
`ifdef FU_ARB_PERF_CNT_EN
  logic        perf_clr;
  logic [31:0] cnt [4];
  int unsigned ms [4];
  int unsigned nxt_s [4];
`endif

  int cmp = 0;
  int errs = 0;

  bit mv [4];
  int mw [4];
  int mp [4];
  bit nxt_v [4];
  int nxt_w [4];
  int nxt_p [4];

  always #5 clk = ~clk;

  fu_issue_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .wf_ready         (wf_ready),
    .fu_simd          (fu[0]),
    .fu_simf          (fu[1]),
    .fu_salu          (fu[2]),
    .fu_lsu           (fu[3]),
    .flush_valid      (flush_valid),
    .flush_wfid       (flush_wfid),
    .simd_issue_ready (rdy[0]),
    .simf_issue_ready (rdy[1]),
    .salu_issue_ready (rdy[2]),
    .lsu_issue_ready  (rdy[3]),
    .simd_issue_valid (v[0]),
    .simf_issue_valid (v[1]),
    .salu_issue_valid (v[2]),
    .lsu_issue_valid  (v[3]),
    .simd_issue_wfid  (w[0]),
    .simf_issue_wfid  (w[1]),
    .salu_issue_wfid  (w[2]),
    .lsu_issue_wfid   (w[3]),
`ifdef FU_ARB_PERF_CNT_EN
    .perf_clr         (perf_clr),
    .simd_stall_cnt   (cnt[0]),
    .simf_stall_cnt   (cnt[1]),
    .salu_stall_cnt   (cnt[2]),
    .lsu_stall_cnt    (cnt[3]),
`endif
    .issued_mask      (issued_mask)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 4; l++) begin
      mv[l] = 0;
      mw[l] = 0;
      mp[l] = 0;
`ifdef FU_ARB_PERF_CNT_EN
      ms[l] = 0;
`endif
    end
  endtask

  function automatic logic [39:0] bitof(input int i);
    logic [39:0] b;
    b = '0;
    b[i] = 1'b1;
    return b;
  endfunction

  task automatic compare();
    logic [39:0] em;
    em = '0;
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("valid%0d", l), 64'(v[l]), 64'(mv[l]));
      if (mv[l]) chk($sformatf("wfid%0d", l), 64'(w[l]), 64'(mw[l]));
      if (mv[l] && rdy[l]) em[mw[l]] = 1'b1;
`ifdef FU_ARB_PERF_CNT_EN
      chk($sformatf("stall%0d", l), 64'(cnt[l]), 64'(ms[l]));
`endif
    end
    chk("issued_mask", 64'(issued_mask), 64'(em));
    for (int a = 0; a < 4; a++)
      for (int b = a + 1; b < 4; b++)
        if (v[a] && v[b])
          chk($sformatf("unique%0d%0d", a, b), 64'(w[a] != w[b]), 64'd1);
  endtask

  task automatic model_next();
    bit used [NW];
    bit hs;
    bit fl;
    int start;
    int c;
    for (int i = 0; i < NW; i++) used[i] = 0;
    for (int l = 0; l < 4; l++) if (mv[l]) used[mw[l]] = 1;
    for (int l = 0; l < 4; l++) begin
      hs = mv[l] && rdy[l];
      nxt_v[l] = mv[l];
      nxt_w[l] = mw[l];
      nxt_p[l] = mp[l];
      if (mv[l] && !hs) begin
        if (flush_valid && int'(flush_wfid) == mw[l]) nxt_v[l] = 0;
      end else begin
        start = hs ? (mw[l] + 1) % NW : mp[l];
        nxt_p[l] = start;
        nxt_v[l] = 0;
        for (int o = 0; o < NW; o++) begin
          c = (start + o) % NW;
          fl = flush_valid && int'(flush_wfid) == c;
          if (!nxt_v[l] && wf_ready[c] && fu[l][c] && !used[c] && !fl) begin
            nxt_v[l] = 1;
            nxt_w[l] = c;
            used[c] = 1;
          end
        end
      end
`ifdef FU_ARB_PERF_CNT_EN
      if (perf_clr) nxt_s[l] = 0;
      else if (mv[l] && !rdy[l] && ms[l] != 32'hFFFF_FFFF)
        nxt_s[l] = ms[l] + 1;
      else nxt_s[l] = ms[l];
`endif
    end
  endtask

  task automatic step();
    #1;
    compare();
    model_next();
    @(posedge clk);
    #1;
    for (int l = 0; l < 4; l++) begin
      mv[l] = nxt_v[l];
      mw[l] = nxt_w[l];
      mp[l] = nxt_p[l];
`ifdef FU_ARB_PERF_CNT_EN
      ms[l] = nxt_s[l];
`endif
    end
  endtask

  task automatic quiesce();
    wf_ready = '0;
    for (int l = 0; l < 4; l++) begin
      fu[l] = '0;
      rdy[l] = 1'b1;
    end
    flush_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    int seq [4];
    seq = '{3, 10, 39, 3};
    rst = 1'b0;
    wf_ready = '0;
    flush_valid = 1'b0;
    flush_wfid = '0;
    for (int l = 0; l < 4; l++) begin
      fu[l] = '0;
      rdy[l] = 1'b0;
    end
`ifdef FU_ARB_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("rst_valid%0d", l), 64'(v[l]), 64'd0);
      chk($sformatf("rst_wfid%0d", l), 64'(w[l]), 64'd0);
    end
    chk("rst_issued", 64'(issued_mask), 64'd0);
    rst = 1'b1;

    // single grant on simd, wfid 5
    wf_ready = bitof(5);
    fu[0] = bitof(5);
    step();
    chk("simd5_valid", 64'(v[0]), 64'd1);
    chk("simd5_wfid", 64'(w[0]), 64'd5);
    rdy[0] = 1'b1;
    wf_ready = '0;
    #1;
    chk("simd5_issued", 64'(issued_mask), 64'(bitof(5)));
    step();
    wf_ready = bitof(2) | bitof(7);
    fu[0] = wf_ready;
    step();
    chk("simd_rr_after5", 64'(w[0]), 64'd7);
    quiesce();

    // back-to-back salu with wrap
    wf_ready = bitof(3) | bitof(10) | bitof(39);
    fu[2] = wf_ready;
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("salu_seq%0d_v", i), 64'(v[2]), 64'd1);
      chk($sformatf("salu_seq%0d_w", i), 64'(w[2]), 64'(seq[i]));
      step();
    end
    quiesce();

    // lsu held on wfid 7 while stalled
    wf_ready = bitof(7);
    fu[3] = bitof(7);
    rdy[3] = 1'b0;
`ifdef FU_ARB_PERF_CNT_EN
    perf_clr = 1'b1;
`endif
    step();
`ifdef FU_ARB_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    wf_ready = '0;
    for (int i = 0; i < 4; i++) begin
      chk("lsu_hold_v", 64'(v[3]), 64'd1);
      chk("lsu_hold_w", 64'(w[3]), 64'd7);
      step();
    end
    chk("lsu_hold_v_end", 64'(v[3]), 64'd1);
`ifdef FU_ARB_PERF_CNT_EN
    chk("lsu_stall4", 64'(cnt[3]), 64'd4);
`endif
    quiesce();

    // simf flush without and with handshake
    wf_ready = bitof(12);
    fu[1] = bitof(12);
    rdy[1] = 1'b0;
    step();
    chk("simf12_v", 64'(v[1]), 64'd1);
    flush_valid = 1'b1;
    flush_wfid = 6'd12;
    wf_ready = '0;
    step();
    chk("simf_flush_v", 64'(v[1]), 64'd0);
    flush_valid = 1'b0;
    wf_ready = bitof(12);
    step();
    chk("simf12b_w", 64'(w[1]), 64'd12);
    flush_valid = 1'b1;
    rdy[1] = 1'b1;
    wf_ready = '0;
    #1;
    chk("simf_flush_hs", 64'(issued_mask), 64'(bitof(12)));
    step();
    flush_valid = 1'b0;
    quiesce();

    // overlapping class: simd wins wfid 20
    for (int l = 0; l < 4; l++) rdy[l] = 1'b0;
    wf_ready = bitof(20) | bitof(25);
    fu[0] = bitof(20);
    fu[1] = bitof(20) | bitof(25);
    step();
    chk("ovl_simd_w", 64'(w[0]), 64'd20);
    chk("ovl_simf_not20", 64'(v[1] && w[1] == 6'd20), 64'd0);

    // async reset while all lanes hold
    wf_ready = wf_ready | bitof(1) | bitof(2);
    fu[2] = bitof(1);
    fu[3] = bitof(2);
    step();
    #2;
    rst = 1'b0;
    #1;
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("arst_v%0d", l), 64'(v[l]), 64'd0);
      chk($sformatf("arst_w%0d", l), 64'(w[l]), 64'd0);
    end
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
    wf_ready = bitof(0) | bitof(30);
    fu[0] = wf_ready;
    fu[1] = '0;
    fu[2] = '0;
    fu[3] = '0;
    step();
    chk("post_rst_w", 64'(w[0]), 64'd0);
    quiesce();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      wf_ready = {8'($urandom), $urandom};
      for (int l = 0; l < 4; l++) begin
        fu[l] = {8'($urandom), $urandom} & {8'($urandom), $urandom};
        rdy[l] = ($urandom_range(0, 2) == 0);
      end
      flush_valid = ($urandom_range(0, 3) == 0);
      flush_wfid = 6'($urandom_range(0, NW - 1));
`ifdef FU_ARB_PERF_CNT_EN
      perf_clr = ($urandom_range(0, 19) == 0);
`endif
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule

// File: doc/fu_issue_arbiter.md
Name: fu_issue_arbiter

Overview:
- Per-functional-unit issue scheduler behind the functional-unit register bank.
- Takes the per-wavefront FU-class masks (fu_simd, fu_simf, fu_salu, fu_lsu) and a per-wavefront ready mask.
- For each of the four FUs, picks one wavefront round-robin and holds it on a valid/ready handshake until the FU accepts it.
- Also reports accepted wavefronts so upstream can clear their ready bits.

Parameters:
- NUM_WF, 40 (`WF_PER_CU): wavefront slots per CU.
- WFID_W, 6 (`WF_ID_LENGTH): wavefront id width.
- NUM_FU, 4: lanes, fixed order SIMD=0, SIMF=1, SALU=2, LSU=3.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- wf_ready  in  NUM_WF  wavefront has an instruction ready to issue.
- fu_simd, fu_simf, fu_salu, fu_lsu  in  NUM_WF each  FU class of each wavefront's next instruction.
- flush_valid  in  1  flush request for one wavefront.
- flush_wfid  in  WFID_W  wavefront being flushed.
- simd_issue_ready, simf_issue_ready, salu_issue_ready, lsu_issue_ready  in  1 each  FU accepts this cycle.
- simd_issue_valid, simf_issue_valid, salu_issue_valid, lsu_issue_valid  out  1 each  issue request.
- simd_issue_wfid, simf_issue_wfid, salu_issue_wfid, lsu_issue_wfid  out  WFID_W each  issued wavefront.
- issued_mask  out  NUM_WF  one-hot per FU lane, OR of all lanes; bit set for the cycle its handshake completes.

Behaviour:
- Reset (rst=0, async): all *_issue_valid=0, all *_issue_wfid=0, all rr_ptr=0, all lanes IDLE, issued_mask=0. Deassertion is synchronised to clk by the integrator.
- Per lane: eligible = wf_ready & fu_<lane> & ~lock, where lock = wfids currently held valid on any lane.
  - Priority among lanes for lock: SIMD > SIMF > SALU > LSU.
  - The lock ensures no wfid is ever valid on two lanes simultaneously.
- Selection: the first set bit of eligible at index >= rr_ptr, wrapping 39 -> 0. An empty eligible set means no selection.
- Lane FSM:
  - IDLE: if there is a selection, register valid=1 and wfid=sel, then go to ISSUE. Latency is 1 cycle from wf_ready rising to valid.
  - ISSUE: valid and wfid held stable; falling wf_ready is ignored (no retraction).
  - ISSUE, on handshake (valid & ready):
    - issued_mask[wfid]=1 combinationally that cycle.
    - rr_ptr <= wfid+1, wrapping 39 -> 0.
    - The next selection excludes the accepted wfid. If a selection exists, stay in ISSUE with the new wfid (back-to-back, no bubble); else go to IDLE with valid=0.
  - ISSUE, on flush with flush_wfid==held wfid and no handshake: valid=0 next cycle, go to IDLE, rr_ptr unchanged.
  - Flush and handshake in the same cycle: the handshake wins (issued_mask set, normal advance).
  - Flush of a wfid not currently held: no effect on the lane. The flushed wfid is also removed from eligible that cycle.
- rr_ptr arithmetic is modulo NUM_WF, not 2^WFID_W. Values 40..63 never occur.
- fu_* overlap (a wfid in two classes) is an upstream error. Each lane still arbitrates independently, and the lock prevents double issue.

Optional Feature:
- Macro: FU_ARB_PERF_CNT_EN.
- Defined: adds four 32-bit outputs simd_stall_cnt, simf_stall_cnt, salu_stall_cnt, lsu_stall_cnt.
  - Each counts cycles with valid=1 and ready=0, saturating at 0xFFFFFFFF.
  - Reset to 0; also cleared by a new input perf_clr (1 bit, synchronous).
- Undefined: counters, perf_clr and the stall outputs are absent. Handshake behaviour is identical in both builds.

Decomposition:
- Shared package/defines: `WF_PER_CU, `WF_ID_LENGTH, FU lane index constants, lane FSM state encoding (IDLE=1'b0, ISSUE=1'b1).
- Sub-module fu_issue_lane_arb: one lane FSM, round-robin pointer and wrap-around priority encoder (NUM_WF -> WFID_W).
  - Instantiated 4 times.
  - Top level holds the lock chain, issued_mask OR and the optional counters.

Test Plan:
- Reset then wf_ready=bit5, fu_simd=bit5 -> simd_issue_valid=1, wfid=5 one cycle later; ready=1 -> issued_mask=bit5, rr_ptr=6.
- wf_ready/fu_salu = bits 3,10,39, rr_ptr=0, salu_issue_ready held 1 -> wfids 3,10,39,3 issued back-to-back with no bubble (wrap 39 -> 0).
- lsu held valid on wfid 7, lsu_issue_ready=0 for 4 cycles, wf_ready[7] drops -> valid and wfid=7 stable; with FU_ARB_PERF_CNT_EN, lsu_stall_cnt=4.
- simf holding wfid 12; flush_valid=1, flush_wfid=12, ready=0 -> simf_issue_valid=0 next cycle. Repeat with ready=1 same cycle -> issued_mask=bit12, normal advance.
- wfid 20 set in both fu_simd and fu_simf, ready -> only simd_issue_valid shows 20; simf stays IDLE or picks another wfid.
- rst=0 asserted mid-ISSUE on all lanes, no clock edge -> all valids and wfids 0 immediately; after release, first grant starts from rr_ptr=0.
